// File: rtl/bram_mem_responder.sv
// rtl/bram_mem_responder.sv - BRAM-backed stand-in for the SDRAM controller's request/busy handshake
module bram_mem_responder #(
    parameter int ADDR_WIDTH     = 14,
    parameter int RD_LATENCY     = 4,
    parameter int WR_LATENCY     = 2,
    parameter int REFRESH_CYCLES = 8,
    parameter int INIT_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic        read_a,
    input  logic        read_b,
    input  logic        write,
    input  logic        refresh,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [3:0]  mask,
    output logic [31:0] dout_a,
    output logic [31:0] dout_b,
    output logic        busy,
    output logic        mem_initialized,
    output logic        fail,
    output logic [31:0] total_written
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
    localparam logic [7:0] RD_LOAD   = 8'(RD_LATENCY - 1);
    localparam logic [7:0] WR_LOAD   = 8'(WR_LATENCY - 1);
    localparam logic [7:0] RF_LOAD   = 8'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ_A,
        ST_READ_B,
        ST_WRITE,
        ST_REFRESH
    } state_t;

    state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       accept;
    logic       done;
    logic       init_done;

    logic [ADDR_WIDTH-1:0] lat_idx;
    logic [31:0]           lat_din;
    logic [3:0]            lat_mask;
    logic                  lat_oor;

    logic [31:0] mem [0:DEPTH-1];

    logic addr_oor;
    logic unused_addr_lsbs;
    assign addr_oor         = (addr[31:ADDR_WIDTH+2] != '0);
    assign unused_addr_lsbs = ^addr[1:0];

    // INIT counts up from the cleared counter; service states count down to zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        done      = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_INIT: begin
                if (cnt == INIT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 8'd0;
                    init_done = 1'b1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ST_IDLE: begin
                accept = write | read_a | read_b | refresh;
                if (write) begin
                    state_nxt = ST_WRITE;
                    cnt_nxt   = WR_LOAD;
                end else if (read_a) begin
                    state_nxt = ST_READ_A;
                    cnt_nxt   = RD_LOAD;
                end else if (read_b) begin
                    state_nxt = ST_READ_B;
                    cnt_nxt   = RD_LOAD;
                end else if (refresh) begin
                    state_nxt = ST_REFRESH;
                    cnt_nxt   = RF_LOAD;
                end
            end
            default: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state <= ST_INIT;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            busy            <= 1'b1;
            mem_initialized <= 1'b0;
            fail            <= 1'b0;
            total_written   <= 32'd0;
            dout_a          <= 32'd0;
            dout_b          <= 32'd0;
            lat_idx         <= '0;
            lat_din         <= 32'd0;
            lat_mask        <= 4'hF;
            lat_oor         <= 1'b0;
        end else begin
            if (init_done) begin
                busy            <= 1'b0;
                mem_initialized <= 1'b1;
            end
            if (accept) begin
                busy     <= 1'b1;
                lat_idx  <= addr[ADDR_WIDTH+1:2];
                lat_din  <= din;
                lat_mask <= mask;
                lat_oor  <= addr_oor;
                if (addr_oor && (write || read_a || read_b))
                    fail <= 1'b1;
            end
            if (done) begin
                busy <= 1'b0;
                if (state == ST_READ_A)
                    dout_a <= lat_oor ? 32'd0 : mem[lat_idx];
                if (state == ST_READ_B)
                    dout_b <= lat_oor ? 32'd0 : mem[lat_idx];
                if (state == ST_WRITE)
                    total_written <= total_written + 32'd1;
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (done && state == ST_WRITE && !lat_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (!lat_mask[i])
                    mem[lat_idx][8*i +: 8] <= lat_din[8*i +: 8];
            end
        end
    end

endmodule
